// File: rtl/sp_ram_arb2.sv
// Two-master round-robin front end for a single-port word SRAM with a 1-cycle registered read.
// Returns rvalid/rdata to the owning master one cycle after grant and keeps saturating stall counters.
`timescale 1ns/1ps
module sp_ram_arb2 #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH+1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  output logic [CNT_WIDTH-1:0]  m0_stall_cnt_o,

  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH+1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic [CNT_WIDTH-1:0]  m1_stall_cnt_o,

  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 prio_q, prio_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_owner_q, rsp_owner_d;
  logic                 rsp_write_q, rsp_write_d;
  logic [CNT_WIDTH-1:0] stall0_q, stall0_d;
  logic [CNT_WIDTH-1:0] stall1_q, stall1_d;
  logic                 gnt0, gnt1;

  // The byte-offset bits are part of the master address but never reach the word-wide SRAM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  // Round-robin arbitration; grants are forced low while reset is held.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (m0_req_i && m1_req_i) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = m0_req_i;
        gnt1 = m1_req_i;
      end
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    if (gnt0) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = m0_addr_i[ADDR_WIDTH+1:2];
      ram_wdata_o = m0_wdata_i;
      ram_we_o    = m0_we_i;
      ram_be_o    = m0_we_i ? m0_be_i : 4'hF;
    end else if (gnt1) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = m1_addr_i[ADDR_WIDTH+1:2];
      ram_wdata_o = m1_wdata_i;
      ram_we_o    = m1_we_i;
      ram_be_o    = m1_we_i ? m1_be_i : 4'hF;
    end
  end

  always_comb begin
    prio_d      = prio_q;
    rsp_valid_d = gnt0 | gnt1;
    rsp_owner_d = gnt1;
    rsp_write_d = gnt1 ? m1_we_i : m0_we_i;
    stall0_d    = stall0_q;
    stall1_d    = stall1_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
    if (m0_req_i && !gnt0 && stall0_q != CNT_MAX) stall0_d = stall0_q + CNT_ONE;
    if (m1_req_i && !gnt1 && stall1_q != CNT_MAX) stall1_d = stall1_q + CNT_ONE;
  end

  // NOTE: state registers use non-blocking assignments and a reset tested inside the clocked block,
  // so reset is synchronous and every register updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_write_q <= 1'b0;
      stall0_q    <= '0;
      stall1_q    <= '0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_write_q <= rsp_write_d;
      stall0_q    <= stall0_d;
      stall1_q    <= stall1_d;
    end
  end

  assign m0_rvalid_o    = rsp_valid_q & ~rsp_owner_q;
  assign m1_rvalid_o    = rsp_valid_q & rsp_owner_q;
  assign m0_rdata_o     = (m0_rvalid_o && !rsp_write_q) ? ram_rdata_i : 32'h0;
  assign m1_rdata_o     = (m1_rvalid_o && !rsp_write_q) ? ram_rdata_i : 32'h0;
  assign m0_stall_cnt_o = stall0_q;
  assign m1_stall_cnt_o = stall1_q;

endmodule

// File: tb/tb_sp_ram_arb2.sv
// Scoreboard bench for sp_ram_arb2: an SRAM model, a rule-level reference model that predicts grants,
// SRAM drive, stall counts and responses, and a monitor that pops expected responses when they fall due.
`timescale 1ns/1ps
module tb_sp_ram_arb2;

  localparam int AW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW+1:0] m0_addr, m1_addr;
  logic [3:0]    m0_be, m1_be;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [CW-1:0] m0_stall, m1_stall;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_be;
  bit   [31:0]   ram_rdata;

  sp_ram_arb2 #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_stall_cnt_o(m0_stall),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_stall_cnt_o(m1_stall),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
    .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
  );

  // Environment SRAM: byte-enabled write, registered read.
  bit [31:0] sram [1 << AW];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) sram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= sram[ram_addr];
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state.
  typedef struct {
    int        due;
    bit        owner;
    bit [31:0] data;
  } rsp_t;
  rsp_t      sb[$];
  bit [31:0] ref_mem [1 << AW];
  bit        m_prio = 1'b0;
  int        m_cnt0 = 0;
  int        m_cnt1 = 0;

  // Issue side: predict this cycle's arbitration and SRAM drive, queue the response for the next cycle.
  always @(negedge clk) begin
    bit            r0, r1, g0, g1, w_we;
    logic [AW+1:0] w_addr;
    logic [3:0]    w_be;
    logic [31:0]   w_wd;
    int            word;
    r0 = m0_req;
    r1 = m1_req;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      if (r0 && r1) begin
        g0 = (m_prio == 1'b0);
        g1 = (m_prio == 1'b1);
      end else begin
        g0 = r0;
        g1 = r1;
      end
    end
    check("gnt0", m0_gnt, g0);
    check("gnt1", m1_gnt, g1);
    check("stall0", m0_stall, m_cnt0);
    check("stall1", m1_stall, m_cnt1);
    if (g0 || g1) begin
      w_addr = g1 ? m1_addr  : m0_addr;
      w_we   = g1 ? m1_we    : m0_we;
      w_be   = g1 ? m1_be    : m0_be;
      w_wd   = g1 ? m1_wdata : m0_wdata;
      word   = int'(w_addr) / 4;
      check("ram_en", ram_en, 1);
      check("ram_addr", ram_addr, word);
      check("ram_we", ram_we, w_we);
      check("ram_be", ram_be, w_we ? w_be : 4'hF);
      check("ram_wdata", ram_wdata, w_wd);
      if (w_we) begin
        for (int b = 0; b < 4; b++)
          if (w_be[b]) ref_mem[word][b*8 +: 8] = w_wd[b*8 +: 8];
        sb.push_back('{due: cyc + 1, owner: g1, data: 32'h0});
      end else begin
        sb.push_back('{due: cyc + 1, owner: g1, data: ref_mem[word]});
      end
      m_prio = g0;
    end else begin
      check("ram_idle", {ram_en, ram_we, ram_be, ram_addr, ram_wdata}, 0);
    end
    if (r0 && !g0 && m_cnt0 < CMAX) m_cnt0++;
    if (r1 && !g1 && m_cnt1 < CMAX) m_cnt1++;
    if (!rst_n) begin
      m_prio = 1'b0;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end
  end

  // Monitor: compares the response outputs against whatever entry is due this cycle.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst_n) begin
      while (sb.size() > 0 && sb[0].due <= cyc) sb.delete(0);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rvalid", {m1_rvalid, m0_rvalid}, e.owner ? 2'b10 : 2'b01);
      check("rdata0", m0_rdata, e.owner ? 32'h0 : e.data);
      check("rdata1", m1_rdata, e.owner ? e.data : 32'h0);
    end else begin
      check("no_rsp", {m1_rvalid, m0_rvalid, m1_rdata, m0_rdata}, 0);
    end
  end

  logic gl0 = 1'b0, gl1 = 1'b0;
  always @(negedge clk) begin
    gl0 <= m0_gnt;
    gl1 <= m1_gnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int id, input bit req, input logic [AW+1:0] addr, input bit we,
                       input logic [3:0] be, input logic [31:0] wd);
    if (id == 0) begin
      m0_req = req; m0_addr = addr; m0_we = we; m0_be = be; m0_wdata = wd;
    end else begin
      m1_req = req; m1_addr = addr; m1_we = we; m1_be = be; m1_wdata = wd;
    end
  endtask

  task automatic idle_all();
    set_m(0, 0, '0, 0, 4'h0, 32'h0);
    set_m(1, 0, '0, 0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Write then immediately read back the same word.
    set_m(1, 1, 10'h010, 1, 4'hF, 32'hDEADBEEF);
    step();
    set_m(1, 1, 10'h010, 0, 4'h0, 32'h0);
    step();
    idle_all();
    @(negedge clk);
    check("t1_rdata", m1_rdata, 32'hDEADBEEF);
    step();

    // Continuous contention after reset alternates and splits the stalls evenly.
    do_reset();
    set_m(0, 1, 10'h040, 0, 4'h0, 32'h0);
    set_m(1, 1, 10'h044, 0, 4'h0, 32'h0);
    repeat (6) step();
    idle_all();
    @(negedge clk);
    check("t2_stall0", m0_stall, 3);
    check("t2_stall1", m1_stall, 3);
    step();

    // Partial byte write merges into an existing word.
    set_m(0, 1, 10'h020, 1, 4'hF, 32'h11223344);
    step();
    set_m(0, 1, 10'h020, 1, 4'b0100, 32'h00AA0000);
    step();
    set_m(0, 1, 10'h020, 0, 4'h0, 32'h0);
    step();
    idle_all();
    @(negedge clk);
    check("t3_rdata", m0_rdata, 32'h11AA3344);
    step();

    // Reset right after a granted read drops the response and restores priority to m0.
    set_m(0, 1, 10'h020, 0, 4'h0, 32'h0);
    step();
    idle_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_m(0, 1, 10'h030, 0, 4'h0, 32'h0);
    set_m(1, 1, 10'h034, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("t4_no_rvalid", m0_rvalid, 0);
    check("t4_gnt_m0", {m1_gnt, m0_gnt}, 2'b01);
    check("t4_cnt", {m1_stall, m0_stall}, 0);
    step();
    idle_all();
    step();

    // Lone requester is always granted, and the other master wins at once afterwards.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_m(0, 1, AW'(i) * 4, 0, 4'h0, 32'h0);
      step();
    end
    idle_all();
    set_m(1, 1, 10'h050, 0, 4'h0, 32'h0);
    @(negedge clk);
    check("t5_gnt_m1", m1_gnt, 1);
    check("t5_cnt", {m1_stall, m0_stall}, 0);
    step();
    idle_all();
    step();

    // Long contention drives both counters into saturation.
    set_m(0, 1, 10'h060, 0, 4'h0, 32'h0);
    set_m(1, 1, 10'h064, 0, 4'h0, 32'h0);
    repeat (40) step();
    idle_all();
    @(negedge clk);
    check("t6_sat1", m1_stall, 4'hF);
    check("t6_sat0", m0_stall, 4'hF);
    step();

    // Random traffic over a small window of words, with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (rst_n && $urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      if (!(m0_req && !gl0))
        set_m(0, $urandom_range(0, 9) < 6, 10'($urandom_range(0, 63)), $urandom_range(0, 1) == 1,
              4'($urandom), $urandom);
      if (!(m1_req && !gl1))
        set_m(1, $urandom_range(0, 9) < 6, 10'($urandom_range(0, 63)), $urandom_range(0, 1) == 1,
              4'($urandom), $urandom);
      step();
    end
    rst_n = 1'b1;
    idle_all();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
